frame_generator_sequencer: RTL and testbench

Run controller for the frame-generator core. It latches frame geometry and a frame count, then soft-resets the core through its control register. It enables streaming and counts accepted output beats to find frame boundaries, and drops enable on exactly the last beat of the run, so the core never emits a surplus beat. It sits between the PS-visible register block and the core: it drives the core's `controlRegister`, `heightWidthRegister` and `dataOutLastPeriod` inputs, and it monitors the core's `dataOutValid`/`dataOutReady` handshake.

---
 rtl/frame_generator_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_frame_generator_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_generator_sequencer.sv
// ---------------------------------------------------------------------------
// frame_generator_sequencer
//
// Run controller for the frame-generator core. On a start it latches the
// frame geometry and frame count, holds the core in soft reset for
// RESET_CYCLES cycles, then enables streaming. It counts accepted output
// beats to find frame boundaries and drops enable on exactly the last beat
// of the run, so the core never emits a surplus beat.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   cmdStart, cmdStop     single-cycle start / graceful-stop pulses
//   cfgWidth, cfgHeight   frame geometry (valid range 1..8191)
//   cfgFrames             frames per run, 0 = continuous until stopped
//   beatValid, beatReady  monitored core output handshake
//   controlRegister       {30'b0, softReset, enable} to the core
//   heightWidthRegister   {height, width} latched at start
//   dataOutLastPeriod     width*NUMPIXELPLANES-1, zero-extended
//   busy                  high in SOFTRESET or RUN
//   frameDone, runDone    registered one-cycle completion pulses
//   cfgError              sticky, set by a start with invalid geometry
//   frameCount            frames completed in the current or last run
//   fsm_state             current FSM state (0 IDLE, 1 SOFTRESET, 2 RUN)
//
// Handshake: a beat is transferred in any cycle where beatValid and
// beatReady are both high at the rising clock edge; valid without ready
// is a stall, and this block only observes the transfer, never drives it.
// ---------------------------------------------------------------------------
module frame_generator_sequencer #(
    parameter int NUMPIXELPLANES = 3,
    parameter int RESET_CYCLES   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmdStart,
    input  logic        cmdStop,
    input  logic [15:0] cfgWidth,
    input  logic [15:0] cfgHeight,
    input  logic [15:0] cfgFrames,
    input  logic        beatValid,
    input  logic        beatReady,
    output logic [31:0] controlRegister,
    output logic [31:0] heightWidthRegister,
    output logic [31:0] dataOutLastPeriod,
    output logic        busy,
    output logic        frameDone,
    output logic        runDone,
    output logic        cfgError,
    output logic [15:0] frameCount,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SOFTRESET = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [15:0] width_q;
    logic [15:0] height_q;
    logic [15:0] frames_q;
    logic [14:0] last_period_q;
    logic [27:0] beats_per_frame_q;
    logic [27:0] beat_cnt_q;
    logic [15:0] frame_count_q;
    logic [3:0]  rst_cnt_q;
    logic        stop_pending_q;
    logic        cfg_error_q;
    logic        frame_done_q;
    logic        run_done_q;

    logic        geom_ok;
    logic        start_req;
    logic        beat;
    logic        frame_last;
    logic        frame_end;
    logic        last_frame;
    logic        terminating;
    logic        rst_done;
    logic [14:0] last_period_calc;
    logic [27:0] beats_per_frame_calc;

    // FSM outputs / datapath strobes from the combinational process
    logic        start_ok;
    logic        start_bad;
    logic        enable;
    logic        soft_reset;

    assign geom_ok   = (cfgWidth  != 16'd0) && (cfgWidth  <= 16'd8191) &&
                       (cfgHeight != 16'd0) && (cfgHeight <= 16'd8191);
    // A simultaneous stop cancels the start outright.
    assign start_req = cmdStart & ~cmdStop;
    assign beat      = beatValid & beatReady;

    // Geometry is at most 13 bits each, so the products fit 15 and 28 bits.
    assign last_period_calc     = (15'(cfgWidth[12:0]) * 15'(NUMPIXELPLANES)) - 15'd1;
    assign beats_per_frame_calc = 28'(cfgWidth[12:0]) * 28'(cfgHeight[12:0]) *
                                  28'(NUMPIXELPLANES);

    assign frame_last  = (beat_cnt_q == beats_per_frame_q - 28'd1);
    assign frame_end   = (state_q == ST_RUN) & beat & frame_last;
    assign last_frame  = (frames_q != 16'd0) && (frame_count_q + 16'd1 == frames_q);
    assign terminating = last_frame | stop_pending_q;
    assign rst_done    = (rst_cnt_q == 4'(RESET_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_ok   = 1'b0;
        start_bad  = 1'b0;
        enable     = 1'b0;
        soft_reset = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    if (geom_ok) begin
                        start_ok = 1'b1;
                        state_d  = ST_SOFTRESET;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            ST_SOFTRESET: begin
                soft_reset = 1'b1;
                if (cmdStop) begin
                    state_d = ST_IDLE;
                end else if (rst_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Enable drops in the same cycle as the terminating beat so the
                // core samples it low and never presents another beat.
                enable = ~(frame_end & terminating);
                if (frame_end & terminating) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            width_q           <= '0;
            height_q          <= '0;
            frames_q          <= '0;
            last_period_q     <= '0;
            beats_per_frame_q <= '0;
            beat_cnt_q        <= '0;
            frame_count_q     <= '0;
            rst_cnt_q         <= '0;
            stop_pending_q    <= 1'b0;
            cfg_error_q       <= 1'b0;
            frame_done_q      <= 1'b0;
            run_done_q        <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            run_done_q   <= 1'b0;

            if (start_ok) begin
                width_q           <= cfgWidth;
                height_q          <= cfgHeight;
                frames_q          <= cfgFrames;
                last_period_q     <= last_period_calc;
                beats_per_frame_q <= beats_per_frame_calc;
                beat_cnt_q        <= '0;
                frame_count_q     <= '0;
                rst_cnt_q         <= '0;
                stop_pending_q    <= 1'b0;
                cfg_error_q       <= 1'b0;
            end

            if (start_bad) begin
                cfg_error_q <= 1'b1;
            end

            if (state_q == ST_SOFTRESET) begin
                rst_cnt_q <= rst_cnt_q + 4'd1;
            end

            if (state_q == ST_RUN) begin
                if (cmdStop) begin
                    stop_pending_q <= 1'b1;
                end
                if (beat) begin
                    if (frame_last) begin
                        beat_cnt_q    <= '0;
                        frame_count_q <= frame_count_q + 16'd1;
                        frame_done_q  <= 1'b1;
                        if (terminating) begin
                            run_done_q     <= 1'b1;
                            stop_pending_q <= 1'b0;
                        end
                    end else begin
                        beat_cnt_q <= beat_cnt_q + 28'd1;
                    end
                end
            end
        end
    end

    assign controlRegister     = {30'b0, soft_reset, enable};
    assign heightWidthRegister = {height_q, width_q};
    assign dataOutLastPeriod   = {17'b0, last_period_q};
    assign busy                = (state_q != ST_IDLE);
    assign frameDone           = frame_done_q;
    assign runDone             = run_done_q;
    assign cfgError            = cfg_error_q;
    assign frameCount          = frame_count_q;
    assign fsm_state           = state_q;

endmodule

// File: tb/tb_frame_generator_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for frame_generator_sequencer. A small core model drives
// beatValid from the enable sampled at the previous edge; run results are
// compared against frame boundaries derived arithmetically from geometry.
// ---------------------------------------------------------------------------
module tb_frame_generator_sequencer;

    localparam int NP = 3;
    localparam int RC = 4;

    typedef struct {
        int          w;
        int          h;
        int          f;
        int          mode;          // 0 ready high, 1 toggling, 2 random
        int          stop_after;    // pulse cmdStop once this many beats seen, 0 = never
        int          restart_beat;  // busy start with other geometry at this beat, 0 = never
        int          exp_beats;     // -1 = derive from stop point
        int          exp_frames;    // -1 = derive from beats
        logic [31:0] exp_lp;
        logic [31:0] exp_hw;
    } run_t;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        cmdStart, cmdStop;
    logic [15:0] cfgWidth, cfgHeight, cfgFrames;
    logic        beatValid, beatReady;
    logic [31:0] controlRegister, heightWidthRegister, dataOutLastPeriod;
    logic        busy, frameDone, runDone, cfgError;
    logic [15:0] frameCount;
    logic [1:0]  fsm_state;

    frame_generator_sequencer #(
        .NUMPIXELPLANES (NP),
        .RESET_CYCLES   (RC)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .cmdStart            (cmdStart),
        .cmdStop             (cmdStop),
        .cfgWidth            (cfgWidth),
        .cfgHeight           (cfgHeight),
        .cfgFrames           (cfgFrames),
        .beatValid           (beatValid),
        .beatReady           (beatReady),
        .controlRegister     (controlRegister),
        .heightWidthRegister (heightWidthRegister),
        .dataOutLastPeriod   (dataOutLastPeriod),
        .busy                (busy),
        .frameDone           (frameDone),
        .runDone             (runDone),
        .cfgError            (cfgError),
        .frameCount          (frameCount),
        .fsm_state           (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    int          ready_mode;
    logic        tog;
    logic        en_prev;
    run_t        vec[5];

    initial begin
        #990_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"},   controlRegister, 0);
        check({tag, "_hw"},     heightWidthRegister, 0);
        check({tag, "_lp"},     dataOutLastPeriod, 0);
        check({tag, "_busy"},   busy, 0);
        check({tag, "_fdone"},  frameDone, 0);
        check({tag, "_rdone"},  runDone, 0);
        check({tag, "_cfgerr"}, cfgError, 0);
        check({tag, "_fcount"}, frameCount, 0);
        check({tag, "_state"},  fsm_state, 0);
    endtask

    // ---------------- driver ----------------
    // Called at a negedge: captures enable, advances one clock, drives the
    // core model's valid from that enable, clears command pulses, and
    // returns at the next negedge for sampling.
    task automatic tick();
        en_prev = controlRegister[0];
        @(posedge clk);
        #1;
        beatValid = en_prev;
        case (ready_mode)
            0:       beatReady = 1'b1;
            1:       begin tog = ~tog; beatReady = tog; end
            default: beatReady = 1'($urandom_range(0, 1));
        endcase
        cmdStart = 1'b0;
        cmdStop  = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_run(input run_t r);
        int beat_n      = 0;
        int last_acc    = 0;
        int sr_cycles   = 0;
        int first_en    = -1;
        int rd_count    = 0;
        int rd_beat     = 0;
        int en_low_cnt  = 0;
        int en_low_beat = 0;
        int n_stop      = 0;
        int post        = 0;
        int bpf;
        int bound;
        int budget;
        int exp_end;
        int exp_frames;
        int c;
        bit stop_sent    = 0;
        bit restart_sent = 0;
        bit done         = 0;
        int fd_seen[$];

        bpf    = r.w * r.h * NP;
        bound  = (r.f == 0) ? (r.stop_after / bpf + 2) * bpf : bpf * r.f;
        budget = 3 * bound + 200;

        cfgWidth   = 16'(r.w);
        cfgHeight  = 16'(r.h);
        cfgFrames  = 16'(r.f);
        ready_mode = r.mode;
        cmdStart   = 1'b1;

        c = 0;
        while (!done && c < budget) begin
            tick();
            c++;
            if (frameDone) begin
                fd_seen.push_back(last_acc);
                check("frame_count_step", frameCount, 32'(fd_seen.size()));
            end
            if (runDone) begin
                rd_count++;
                rd_beat = last_acc;
                check("busy_low_with_run_done", busy, 0);
                check("frame_done_with_run_done", frameDone, 1);
            end
            if (controlRegister[1]) sr_cycles++;
            if (controlRegister[0] && first_en < 0) first_en = c;
            last_acc = 0;
            if (beatValid && beatReady) begin
                beat_n++;
                last_acc = beat_n;
                if (!controlRegister[0]) begin
                    en_low_cnt++;
                    en_low_beat = beat_n;
                end
            end
            if (r.stop_after > 0 && !stop_sent && beat_n >= r.stop_after) begin
                cmdStop   = 1'b1;
                stop_sent = 1;
                n_stop    = beat_n;
            end
            if (r.restart_beat > 0 && !restart_sent && beat_n >= r.restart_beat) begin
                cfgWidth     = 16'd5;
                cfgHeight    = 16'd3;
                cfgFrames    = 16'd9;
                cmdStart     = 1'b1;
                restart_sent = 1;
            end
            if (rd_count > 0) begin
                post++;
                if (post > 4) done = 1;
            end
        end
        check("run_finished_in_budget", 32'(done), 1);

        if (r.exp_beats > 0)  exp_end = r.exp_beats;
        else if (r.f != 0)    exp_end = bpf * r.f;
        else                  exp_end = (n_stop / bpf + 1) * bpf;
        exp_frames = (r.exp_frames > 0) ? r.exp_frames : exp_end / bpf;

        exp_q.delete();
        for (int k = bpf; k <= exp_end; k += bpf) exp_q.push_back(32'(k));
        check("frame_pulse_count", 32'(fd_seen.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && fd_seen.size() > 0)
            check("frame_pulse_beat", 32'(fd_seen.pop_front()), exp_q.pop_front());

        check("total_beats",             beat_n, exp_end);
        check("run_done_count",          rd_count, 1);
        check("run_done_beat",           rd_beat, exp_end);
        check("enable_low_beats",        en_low_cnt, 1);
        check("enable_low_on_last_beat", en_low_beat, exp_end);
        check("soft_reset_cycles",       sr_cycles, RC);
        check("enable_first_cycle",      first_en, RC + 1);
        check("frame_count_final",       frameCount, exp_frames);
        check("last_period",             dataOutLastPeriod, r.exp_lp);
        check("height_width",            heightWidthRegister, r.exp_hw);
        check("busy_after_run",          busy, 0);
        check("cfg_error_after_run",     cfgError, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int rd_seen;
        int en_seen;
        run_t r;

        reset      = 1'b0;
        cmdStart   = 1'b0;
        cmdStop    = 1'b0;
        cfgWidth   = '0;
        cfgHeight  = '0;
        cfgFrames  = '0;
        beatValid  = 1'b0;
        beatReady  = 1'b0;
        ready_mode = 0;
        tog        = 1'b0;

        //            w     h  f  mode stop restart beats frames lp            hw
        vec[0] = '{8191, 1, 1, 0,   0,   0,   24573, 1,     32'd24572,    32'h0001_1FFF};
        vec[1] = '{4,    2, 2, 0,   0,   0,   48,    2,     32'd11,       32'h0002_0004};
        vec[2] = '{4,    2, 2, 1,   0,   0,   48,    2,     32'd11,       32'h0002_0004};
        vec[3] = '{2,    1, 0, 0,   8,   0,   12,    2,     32'd5,        32'h0001_0002};
        vec[4] = '{2,    2, 1, 0,   0,   3,   12,    1,     32'd5,        32'h0002_0002};

        #12;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();

        // Invalid geometry, start+stop collision, stop in soft reset
        cfgWidth = 16'd0; cfgHeight = 16'd2; cfgFrames = 16'd1; cmdStart = 1'b1;
        tick();
        check("bad_width_cfg_error", cfgError, 1);
        check("bad_width_busy", busy, 0);
        check("bad_width_state", fsm_state, 0);
        tick();
        check("bad_width_stays_idle", busy, 0);

        cfgWidth = 16'd4; cmdStart = 1'b1; cmdStop = 1'b1;
        tick();
        check("start_stop_busy", busy, 0);
        check("start_stop_cfg_error_kept", cfgError, 1);
        tick();
        check("start_stop_no_run", fsm_state, 0);

        cmdStart = 1'b1;
        tick();
        check("valid_start_clears_error", cfgError, 0);
        check("valid_start_busy", busy, 1);
        check("soft_reset_control", controlRegister, 32'h2);
        tick();
        cmdStop = 1'b1;
        tick();
        check("stop_in_soft_reset_idle", busy, 0);
        check("stop_in_soft_reset_no_run_done", runDone, 0);
        rd_seen = 0;
        en_seen = 0;
        repeat (8) begin
            tick();
            if (runDone) rd_seen++;
            if (controlRegister[0]) en_seen++;
        end
        check("no_run_done_after_reset_stop", rd_seen, 0);
        check("no_enable_after_reset_stop", en_seen, 0);

        cfgWidth = 16'd4; cfgHeight = 16'd8192; cmdStart = 1'b1;
        tick();
        check("bad_height_cfg_error", cfgError, 1);
        check("bad_height_busy", busy, 0);

        // Asynchronous reset in the middle of a continuous run
        cfgWidth = 16'd1; cfgHeight = 16'd1; cfgFrames = 16'd0; cmdStart = 1'b1;
        ready_mode = 0;
        repeat (12) tick();
        check("mid_run_busy", busy, 1);
        check("mid_run_frames_counted", 32'(frameCount != 16'd0), 1);
        #2 reset = 1'b0;
        #1;
        check_zero("async_reset");
        beatValid = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Directed runs
        for (int i = 0; i < 5; i++) do_run(vec[i]);

        // Randomized runs against the arithmetic frame model
        for (int i = 0; i < 6; i++) begin
            r.w            = int'($urandom_range(1, 4));
            r.h            = int'($urandom_range(1, 3));
            r.mode         = 2;
            r.restart_beat = 0;
            if ($urandom_range(0, 3) == 0) begin
                r.f          = 0;
                r.stop_after = int'($urandom_range(1, 2 * r.w * r.h * NP));
                r.exp_beats  = -1;
                r.exp_frames = -1;
            end else begin
                r.f          = int'($urandom_range(1, 3));
                r.stop_after = 0;
                r.exp_beats  = r.w * r.h * NP * r.f;
                r.exp_frames = r.f;
            end
            r.exp_lp = 32'(r.w * NP - 1);
            r.exp_hw = {16'(r.h), 16'(r.w)};
            do_run(r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
